quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 122 ++++++++++++
 tb/tb_quad_step_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes an A/B encoder pair, emits one-cycle
// up/down/err pulses and keeps a loadable, wrapping position count.
module quad_step_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             up,
  output logic             down,
  output logic             err,
  output logic             err_flag,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t     state_r;
  logic [1:0] fill_r;
  logic [1:0] prev_r;
  logic       s1_a_r, s2_a_r, s1_b_r, s2_b_r;
  logic [1:0] cur_s;
  logic [1:0] delta_s;
  logic       step_up_s, step_dn_s, step_err_s;

  // Position of a phase pair along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase_index(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_index = 2'd0;
      2'b10:   phase_index = 2'd1;
      2'b11:   phase_index = 2'd2;
      2'b01:   phase_index = 2'd3;
      default: phase_index = 2'd0;
    endcase
  endfunction

  // Two-flop synchronizer for each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_r <= 1'b0;
      s2_a_r <= 1'b0;
      s1_b_r <= 1'b0;
      s2_b_r <= 1'b0;
    end else begin
      s1_a_r <= a_in;
      s2_a_r <= s1_a_r;
      s1_b_r <= b_in;
      s2_b_r <= s1_b_r;
    end
  end

  // Step classification from the cyclic distance between current and previous phase.
  always_comb begin
    cur_s      = {s2_a_r, s2_b_r};
    delta_s    = phase_index(cur_s) - phase_index(prev_r);
    step_up_s  = 1'b0;
    step_dn_s  = 1'b0;
    step_err_s = 1'b0;
    if (state_r == ST_TRACK) begin
      case (delta_s)
        2'd1:    step_up_s  = 1'b1;
        2'd2:    step_err_s = 1'b1;
        2'd3:    step_dn_s  = 1'b1;
        default: step_up_s  = 1'b0;
      endcase
    end else begin
      step_up_s  = 1'b0;
      step_dn_s  = 1'b0;
      step_err_s = 1'b0;
    end
  end

  // Tracking FSM with registered pulses, count and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_INIT;
      fill_r   <= 2'd0;
      prev_r   <= 2'b00;
      up       <= 1'b0;
      down     <= 1'b0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      count    <= '0;
    end else begin
      up   <= step_up_s;
      down <= step_dn_s;
      err  <= step_err_s;
      case (state_r)
        ST_INIT: begin
          // prev is captured only once the synchronizer holds post-reset samples
          if (fill_r == 2'd2) begin
            prev_r  <= cur_s;
            state_r <= ST_TRACK;
          end else begin
            fill_r <= fill_r + 2'd1;
          end
        end
        ST_TRACK: prev_r  <= cur_s;
        default:  state_r <= ST_INIT;
      endcase
      if (load) begin
        count    <= data_in;
        err_flag <= 1'b0;
      end else if (step_up_s) begin
        count <= count + WIDTH'(1);
      end else if (step_dn_s) begin
        count <= count - WIDTH'(1);
      end else if (step_err_s) begin
        err_flag <= 1'b1;
      end else begin
        count <= count;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random phase traffic,
// checked every cycle against a sample-history reference model.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b1;
  logic       b_in = 1'b1;
  logic       load = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       up, down, err, err_flag;
  logic [3:0] count;

  quad_step_decoder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .load(load),
    .data_in(data_in), .up(up), .down(down), .err(err),
    .err_flag(err_flag), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: every pin sample since reset release, plus expected outputs.
  logic [1:0] samp_q[$];
  int         m_count = 0;
  logic       m_up = 1'b0, m_dn = 1'b0, m_err = 1'b0, m_flag = 1'b0;
  int         up_total = 0, dn_total = 0, err_total = 0;
  logic [1:0] cur_ab;

  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A decode at edge n sees the pins sampled at edges n-2 (cur) and n-3 (prev).
  task automatic model_edge();
    logic [1:0] cur, prv;
    int n;
    if (rst) begin
      samp_q.delete();
      m_count = 0; m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0; m_flag = 1'b0;
    end else begin
      samp_q.push_back({a_in, b_in});
      n = samp_q.size();
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      if (n >= 4) begin
        cur = samp_q[n-3];
        prv = samp_q[n-4];
        if (cur != prv) begin
          if (fwd_next(prv) == cur)      m_up  = 1'b1;
          else if (fwd_next(cur) == prv) m_dn  = 1'b1;
          else                           m_err = 1'b1;
        end
      end
      if (load) begin
        m_count = int'(data_in);
        m_flag  = 1'b0;
      end else begin
        m_count = (m_count + 16 + int'(m_up) - int'(m_dn)) % 16;
        if (m_err) m_flag = 1'b1;
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 later.
  task automatic cyc(input logic r, input logic [1:0] ab, input logic ld, input logic [3:0] d);
    @(negedge clk);
    rst = r; a_in = ab[1]; b_in = ab[0]; load = ld; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
    if (up === 1'b1)  up_total++;
    if (down === 1'b1) dn_total++;
    if (err === 1'b1) err_total++;
    checks++;
    if ({up, down, err, err_flag, count} !== {m_up, m_dn, m_err, m_flag, 4'(m_count)}) begin
      failures++;
      $display("FAIL cycle t=%0t: got up=%b down=%b err=%b flag=%b count=%0d, expected up=%b down=%b err=%b flag=%b count=%0d",
               $time, up, down, err, err_flag, count, m_up, m_dn, m_err, m_flag, m_count);
    end
  endtask

  task automatic go(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, ab, 1'b0, 4'd0);
    cur_ab = ab;
  endtask

  int b_up, b_dn, b_err;

  initial begin
    cur_ab = 2'b11;
    // T1: reset with 11 held through release
    repeat (3) cyc(1'b1, 2'b11, 1'b0, 4'd0);
    go(2'b11, 3);
    check("t1_count", int'(count), 0);
    go(2'b11, 3);
    check("t1_pulses", up_total + dn_total + err_total, 0);

    // T2: forward cycle from 00
    go(2'b01, 4);
    go(2'b00, 4);
    cyc(1'b0, 2'b00, 1'b1, 4'd0);
    go(2'b00, 3);
    b_up = up_total; b_dn = dn_total;
    go(2'b10, 4); go(2'b11, 4); go(2'b01, 4); go(2'b00, 4);
    check("t2_count", int'(count), 4);
    check("t2_ups", up_total - b_up, 4);
    check("t2_downs", dn_total - b_dn, 0);

    // T3: reverse step wraps 0 -> 15, then 15 forward steps
    cyc(1'b0, 2'b00, 1'b1, 4'd0);
    go(2'b00, 3);
    b_dn = dn_total;
    go(2'b01, 4);
    check("t3_wrap_count", int'(count), 15);
    check("t3_down", dn_total - b_dn, 1);
    for (int i = 0; i < 15; i++) go(fwd_next(cur_ab), 4);
    check("t3_fwd_count", int'(count), 14);

    // T4: illegal 00 -> 11 jump, then load clears the flag
    go(2'b01, 4); go(2'b00, 4);
    b_err = up_total + dn_total; b_up = err_total;
    go(2'b11, 4);
    check("t4_err_pulse", err_total - b_up, 1);
    check("t4_no_step", up_total + dn_total - b_err, 0);
    check("t4_flag", int'(err_flag), 1);
    check("t4_count", int'(count), 0);
    cyc(1'b0, 2'b11, 1'b1, 4'd7);
    go(2'b11, 2);
    check("t4_load_count", int'(count), 7);
    check("t4_load_flag", int'(err_flag), 0);

    // T5: load lands on the same edge a forward step decodes
    cyc(1'b0, 2'b01, 1'b0, 4'd0);
    cyc(1'b0, 2'b01, 1'b0, 4'd0);
    cyc(1'b0, 2'b01, 1'b1, 4'd13);
    check("t5_up", int'(up), 1);
    check("t5_count", int'(count), 13);
    go(2'b01, 3);
    go(2'b11, 4);
    check("t5_rev_count", int'(count), 12);

    // T6: asynchronous reset between edges at count 9
    cyc(1'b0, 2'b11, 1'b1, 4'd9);
    go(2'b11, 3);
    check("t6_pre_count", int'(count), 9);
    #2 rst = 1'b1;
    #1 check("t6_async_count", int'(count), 0);
    repeat (2) cyc(1'b1, 2'b10, 1'b0, 4'd0);
    b_up = up_total; b_dn = dn_total; b_err = err_total;
    go(2'b10, 3);
    check("t6_quiet", (up_total - b_up) + (dn_total - b_dn) + (err_total - b_err), 0);
    go(2'b10, 2);
    go(2'b11, 4);
    check("t6_track_count", int'(count), 1);

    // Random phase traffic with occasional loads and resets
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [1:0] nab;
      sel = $urandom_range(0, 99);
      if (sel < 40)      nab = fwd_next(cur_ab);
      else if (sel < 75) nab = fwd_next(fwd_next(fwd_next(cur_ab)));
      else if (sel < 85) nab = cur_ab;
      else               nab = 2'($urandom_range(0, 3));
      for (int h = 0; h < int'($urandom_range(1, 4)); h++)
        cyc(($urandom_range(0, 149) == 0), nab, ($urandom_range(0, 19) == 0),
            4'($urandom_range(0, 15)));
      cur_ab = nab;
    end
    go(cur_ab, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
